tick_timer: RTL and testbench

//   Programmable down-count timer clocked on clk, advanced by rising edges of the slow clock from the

---
 rtl/timer_pkg.sv | 10 +
 rtl/rise_edge_det.sv | 27 ++
 rtl/tick_timer.sv | 124 ++++++++++++
 tb/tb_tick_timer.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// Shared constants for the tick timer: FSM state encoding and default counter width.
package timer_pkg;

  localparam int TIMER_WIDTH = 16;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_PAUSE = 2'd2;

endpackage

// File: rtl/rise_edge_det.sv
// Rising-edge detector for a signal already registered in the clk domain.
// pulse is combinational: high in the first clk cycle d is seen high.
module rise_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic pulse
);

  logic d_d;
  logic d_q;

  always_comb begin
    d_d = d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d_q <= 1'b0;
    end else begin
      d_q <= d_d;
    end
  end

  assign pulse = d & ~d_q;

endmodule

// File: rtl/tick_timer.sv
// Programmable down-count timer advanced by rising edges of the divided slow clock.
// One-shot or auto-reload, pause/resume, one-cycle expire pulse and sticky irq.
module tick_timer
  import timer_pkg::*;
#(
  parameter int WIDTH = TIMER_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             slow_clk,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             auto_reload,
  input  logic             start,
  input  logic             stop,
  input  logic             irq_clr,
  output logic             tick,
  output logic [WIDTH-1:0] count,
  output logic             running,
  output logic             expire,
  output logic             irq
);

  logic             slow_edge;
  logic [1:0]       state_d,   state_q;
  logic [WIDTH-1:0] count_d,   count_q;
  logic [WIDTH-1:0] reload_d,  reload_q;
  logic             tick_d,    tick_q;
  logic             expire_d,  expire_q;
  logic             irq_d,     irq_q;
  logic             running_d, running_q;

  rise_edge_det u_slow_edge (
    .clk   (clk),
    .rst   (rst),
    .d     (slow_clk),
    .pulse (slow_edge)
  );

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = load ? load_val : reload_q;
    tick_d   = slow_edge;
    expire_d = 1'b0;

    // Count and auto-reload always read reload_q, so a same-cycle load only
    // takes effect from the following reload.
    case (state_q)
      ST_IDLE: begin
        if (start && !stop) begin
          state_d = ST_RUN;
          count_d = reload_q;
        end
      end
      ST_RUN: begin
        if (stop) begin
          state_d = ST_PAUSE;
        end else if (slow_edge) begin
          if (count_q != '0) begin
            count_d = count_q - WIDTH'(1);
          end else begin
            expire_d = 1'b1;
            if (auto_reload) begin
              count_d = reload_q;
            end else begin
              state_d = ST_IDLE;
              count_d = '0;
            end
          end
        end
      end
      ST_PAUSE: begin
        if (stop) begin
          state_d = ST_IDLE;
          count_d = '0;
        end else if (start) begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_IDLE;
        count_d = '0;
      end
    endcase

    if (expire_d) begin
      irq_d = 1'b1;
    end else if (irq_clr) begin
      irq_d = 1'b0;
    end else begin
      irq_d = irq_q;
    end

    running_d = (state_d == ST_RUN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      count_q   <= '0;
      reload_q  <= '0;
      tick_q    <= 1'b0;
      expire_q  <= 1'b0;
      irq_q     <= 1'b0;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      reload_q  <= reload_d;
      tick_q    <= tick_d;
      expire_q  <= expire_d;
      irq_q     <= irq_d;
      running_q <= running_d;
    end
  end

  assign tick    = tick_q;
  assign count   = count_q;
  assign running = running_q;
  assign expire  = expire_q;
  assign irq     = irq_q;

endmodule

// File: tb/tb_tick_timer.sv
// Bench for tick_timer: directed scenarios then random stimulus, all against a behavioural model.
module tb_tick_timer;

  localparam int W = 16;
  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_PAUSE = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         slow_clk = 1'b0;
  logic         load = 1'b0;
  logic [W-1:0] load_val = '0;
  logic         auto_reload = 1'b0;
  logic         start = 1'b0;
  logic         stop = 1'b0;
  logic         irq_clr = 1'b0;
  logic         tick;
  logic [W-1:0] count;
  logic         running;
  logic         expire;
  logic         irq;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  // Reference model state
  bit m_slow, m_tick, m_exp, m_irq;
  int m_mode, m_count, m_reload;
  bit div_en = 1'b1;
  int div_ph = 0;
  int exp_seen;

  tick_timer #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .slow_clk    (slow_clk),
    .load        (load),
    .load_val    (load_val),
    .auto_reload (auto_reload),
    .start       (start),
    .stop        (stop),
    .irq_clr     (irq_clr),
    .tick        (tick),
    .count       (count),
    .running     (running),
    .expire      (expire),
    .irq         (irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic bit edge_pending();
    return slow_clk && !m_slow;
  endfunction

  // One clk cycle: predict from the pre-edge inputs, clock, then compare everything.
  task automatic step();
    int  n_mode, n_count, n_reload;
    bit  n_exp, n_irq, e, s0;
    s0 = slow_clk;
    e  = edge_pending();
    n_mode   = m_mode;
    n_count  = m_count;
    n_reload = load ? int'(load_val) : m_reload;
    n_exp    = 1'b0;
    case (m_mode)
      M_IDLE:  if (start && !stop) begin n_mode = M_RUN; n_count = m_reload; end
      M_RUN: begin
        if (stop) n_mode = M_PAUSE;
        else if (e) begin
          if (m_count > 0) n_count = m_count - 1;
          else begin
            n_exp = 1'b1;
            if (auto_reload) n_count = m_reload;
            else begin n_mode = M_IDLE; n_count = 0; end
          end
        end
      end
      default: begin
        if (stop) begin n_mode = M_IDLE; n_count = 0; end
        else if (start) n_mode = M_RUN;
      end
    endcase
    n_irq = n_exp ? 1'b1 : (irq_clr ? 1'b0 : m_irq);
    @(posedge clk);
    if (rst) begin
      m_slow = 0; m_tick = 0; m_exp = 0; m_irq = 0;
      m_mode = M_IDLE; m_count = 0; m_reload = 0;
    end else begin
      m_slow = s0; m_tick = e; m_exp = n_exp; m_irq = n_irq;
      m_mode = n_mode; m_count = n_count; m_reload = n_reload;
    end
    #1;
    start = 1'b0; stop = 1'b0; load = 1'b0; irq_clr = 1'b0;
    if (div_en) begin
      div_ph++;
      slow_clk = div_ph[1];
    end
    chk("count",   count,   m_count);
    chk("running", running, (m_mode == M_RUN));
    chk("tick",    tick,    m_tick);
    chk("expire",  expire,  m_exp);
    chk("irq",     irq,     m_irq);
  endtask

  task automatic wait_tick();
    bit got = 1'b0;
    for (int i = 0; i < 16 && !got; i++) begin
      step();
      got = m_tick;
    end
    if (!got) chk("tick_timeout", 0, 1);
  endtask

  task automatic wait_edge_pending();
    for (int i = 0; i < 16 && !edge_pending(); i++) step();
    if (!edge_pending()) chk("edge_timeout", 0, 1);
  endtask

  task automatic stop_to_idle();
    stop = 1'b1; step();
    stop = 1'b1; step();
    if (m_mode == M_PAUSE) begin stop = 1'b1; step(); end
  endtask

  initial begin
    m_mode = M_IDLE; m_count = 0; m_reload = 0;
    m_slow = 0; m_tick = 0; m_exp = 0; m_irq = 0;

    // Reset
    repeat (3) step();
    chk("rst_count", count, 0);
    chk("rst_running", running, 0);
    rst = 1'b0;
    load = 1'b1; load_val = 16'd5; step();
    start = 1'b1; step();
    chk("start_count5", count, 5);
    chk("start_running", running, 1);
    rst = 1'b1;
    #1;
    chk("async_rst_count", count, 0);
    chk("async_rst_running", running, 0);
    chk("async_rst_irq", irq, 0);
    chk("async_rst_tick", tick, 0);
    step();
    rst = 1'b0;
    step();

    // One-shot, reload 3
    load = 1'b1; load_val = 16'd3; auto_reload = 1'b0; step();
    start = 1'b1; step();
    chk("os_start", count, 3);
    wait_tick(); chk("os_t1", count, 2);
    wait_tick(); chk("os_t2", count, 1);
    wait_tick(); chk("os_t3", count, 0); chk("os_t3_exp", expire, 0);
    wait_tick();
    chk("os_t4_exp", expire, 1);
    chk("os_t4_running", running, 0);
    chk("os_t4_irq", irq, 1);
    step();
    chk("os_exp_pulse", expire, 0);

    // Auto-reload, reload 1 then 0
    irq_clr = 1'b1; step();
    chk("irq_cleared", irq, 0);
    load = 1'b1; load_val = 16'd1; auto_reload = 1'b1; step();
    start = 1'b1; step();
    exp_seen = 0;
    repeat (6) begin wait_tick(); exp_seen += int'(expire); end
    chk("ar_3_of_6", exp_seen, 3);
    load = 1'b1; load_val = 16'd0; step();
    repeat (2) wait_tick();
    exp_seen = 0;
    repeat (4) begin wait_tick(); exp_seen += int'(expire); end
    chk("ar0_every_tick", exp_seen, 4);
    stop_to_idle();
    chk("abort_count", count, 0);
    chk("abort_running", running, 0);

    // Pause / resume
    load = 1'b1; load_val = 16'd5; auto_reload = 1'b0; step();
    start = 1'b1; step();
    repeat (2) wait_tick();
    chk("pr_pre_stop", count, 3);
    stop = 1'b1; step();
    chk("pr_paused", count, 3);
    chk("pr_paused_run", running, 0);
    repeat (3) wait_tick();
    chk("pr_held", count, 3);
    start = 1'b1; step();
    chk("pr_resumed", running, 1);
    wait_tick();
    chk("pr_resume_dec", count, 2);
    stop = 1'b1; step();
    stop = 1'b1; step();
    chk("pr_abort_count", count, 0);
    chk("pr_abort_running", running, 0);

    // Collisions
    load = 1'b1; load_val = 16'd4; step();
    start = 1'b1; step();
    wait_tick();
    wait_edge_pending();
    exp_seen = m_count;
    stop = 1'b1; step();
    chk("col_stop_edge_count", count, exp_seen);
    chk("col_stop_edge_exp", expire, 0);
    start = 1'b1; stop = 1'b1; step();
    chk("col_ss_pause_running", running, 0);
    chk("col_ss_pause_count", count, 0);
    load = 1'b1; load_val = 16'd0; auto_reload = 1'b1; step();
    start = 1'b1; step();
    wait_edge_pending();
    irq_clr = 1'b1; step();
    chk("col_clr_exp", expire, 1);
    chk("col_clr_irq", irq, 1);
    stop_to_idle();

    // Reload update mid-period
    load = 1'b1; load_val = 16'd2; auto_reload = 1'b1; step();
    start = 1'b1; step();
    chk("ru_start", count, 2);
    wait_tick();
    load = 1'b1; load_val = 16'd7; step();
    for (int i = 0; i < 3 && !m_exp; i++) wait_tick();
    chk("ru_first_exp", expire, 1);
    chk("ru_new_reload", count, 7);
    repeat (7) wait_tick();
    chk("ru_at_zero", count, 0);
    wait_tick();
    chk("ru_second_exp", expire, 1);
    chk("ru_reload_again", count, 7);
    stop_to_idle();

    // Random stimulus against the model
    div_en = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      slow_clk    = 1'($urandom_range(0, 1));
      start       = ($urandom % 4) == 0;
      stop        = ($urandom % 7) == 0;
      load        = ($urandom % 8) == 0;
      load_val    = W'($urandom_range(0, 5));
      auto_reload = 1'($urandom_range(0, 1));
      irq_clr     = ($urandom % 6) == 0;
      rst         = ($urandom % 150) == 0;
      step();
    end
    rst = 1'b0;
    step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
